// File: rtl/div_pkg.sv
// Shared definitions for the iterative integer divider: operand width,
// operation encodings and the controller state type.
package div_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_sign_fix.sv
// Combinational sign handling around the unsigned restoring divider.
// Extracts operand magnitudes for the datapath, flags divisor-zero and
// signed-overflow requests, and turns the raw unsigned quotient/remainder
// into the architectural result (including the special-case values).
module div_sign_fix
    import div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] rem_i,
    output logic [XLEN-1:0] mag1_o,
    output logic [XLEN-1:0] mag2_o,
    output logic            special_o,
    output logic [XLEN-1:0] result_o
);

    logic                   is_signed;
    logic                   neg1;
    logic                   neg2;
    logic                   div_zero;
    logic                   overflow;
    logic signed [XLEN-1:0] rs1_s;
    logic signed [XLEN-1:0] rs2_s;
    logic [XLEN-1:0]        quo_fix;
    logic [XLEN-1:0]        rem_fix;

    // Magnitudes, special-case detection and final sign correction.
    always_comb begin
        rs1_s     = $signed(rs1_i);
        rs2_s     = $signed(rs2_i);
        // Odd encodings (DIVU/REMU) are the unsigned ones.
        is_signed = ~op_i[0];
        neg1      = is_signed & (rs1_s < 0);
        neg2      = is_signed & (rs2_s < 0);
        // Negating 0x80000000 leaves 0x80000000, which is the correct
        // unsigned magnitude, so no extra width is needed.
        mag1_o    = neg1 ? (~rs1_i + 1'b1) : rs1_i;
        mag2_o    = neg2 ? (~rs2_i + 1'b1) : rs2_i;

        div_zero  = (rs2_i == '0);
        overflow  = is_signed & (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_i == {XLEN{1'b1}});
        special_o = div_zero | overflow;

        if (div_zero) begin
            quo_fix = {XLEN{1'b1}};
            rem_fix = rs1_i;
        end else if (overflow) begin
            quo_fix = {1'b1, {(XLEN-1){1'b0}}};
            rem_fix = '0;
        end else begin
            // Quotient negative when signs differ; remainder follows dividend.
            quo_fix = (neg1 ^ neg2) ? (~quo_i + 1'b1) : quo_i;
            rem_fix = neg1 ? (~rem_i + 1'b1) : rem_i;
        end

        result_o = op_i[1] ? rem_fix : quo_fix;
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
// IDLE accepts a request, CALC runs one shift/subtract step per cycle for
// 32 cycles, DONE presents the result for one cycle.
// Optional macro DIV_BYPASS_EN: divisor-zero and signed-overflow requests
// jump straight from IDLE to DONE instead of iterating.
module div_unit
    import div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      rd_tag_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_tag_o
);

    localparam int CNT_W = $clog2(XLEN);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [XLEN-1:0]  rs1_q, rs1_d;
    logic [XLEN-1:0]  rs2_q, rs2_d;
    logic [4:0]       tag_q, tag_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic [XLEN-1:0]  res_hold_q, res_hold_d;
    logic [4:0]       tag_hold_q, tag_hold_d;

    logic [1:0]       fix_op;
    logic [XLEN-1:0]  fix_rs1;
    logic [XLEN-1:0]  fix_rs2;
    logic [XLEN-1:0]  mag1;
    logic [XLEN-1:0]  mag2;
    logic             special;
    logic [XLEN-1:0]  fix_result;

    logic [XLEN:0]    shifted;
    logic [XLEN:0]    diff;
    logic             fits;

    // In IDLE the sign unit looks at the incoming request (magnitudes to load);
    // afterwards it looks at the latched request (final correction in DONE).
    always_comb begin
        if (state_q == ST_IDLE) begin
            fix_op  = op_i;
            fix_rs1 = rs1_i;
            fix_rs2 = rs2_i;
        end else begin
            fix_op  = op_q;
            fix_rs1 = rs1_q;
            fix_rs2 = rs2_q;
        end
    end

    div_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .op_i      (fix_op),
        .rs1_i     (fix_rs1),
        .rs2_i     (fix_rs2),
        .quo_i     (quo_q),
        .rem_i     (rem_q),
        .mag1_o    (mag1),
        .mag2_o    (mag2),
        .special_o (special),
        .result_o  (fix_result)
    );

`ifndef DIV_BYPASS_EN
    logic special_unused;
    assign special_unused = special;
`endif

    // Controller next state plus one restoring step of the datapath.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        tag_d      = tag_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        dvs_d      = dvs_q;
        res_hold_d = res_hold_q;
        tag_hold_d = tag_hold_q;

        // Partial remainder shifted left with the next dividend bit brought in
        // from the top of the quotient register.
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};
        fits    = ~diff[XLEN];

        case (state_q)
            ST_IDLE: begin
                if (start_i && !flush_i) begin
                    op_d    = op_i;
                    rs1_d   = rs1_i;
                    rs2_d   = rs2_i;
                    tag_d   = rd_tag_i;
                    quo_d   = mag1;
                    rem_d   = '0;
                    dvs_d   = mag2;
                    cnt_d   = '0;
                    state_d = ST_CALC;
`ifdef DIV_BYPASS_EN
                    if (special) begin
                        state_d = ST_DONE;
                    end
`endif
                end
            end
            ST_CALC: begin
                rem_d = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], fits};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                res_hold_d = fix_result;
                tag_hold_d = tag_q;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (flush_i) begin
            state_d = ST_IDLE;
        end
    end

    // Control state and architecturally visible result holding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            res_hold_q <= '0;
            tag_hold_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            res_hold_q <= res_hold_d;
            tag_hold_q <= tag_hold_d;
        end
    end

    // Datapath registers; only meaningful while a request is in flight.
    always_ff @(posedge clk) begin
        op_q  <= op_d;
        rs1_q <= rs1_d;
        rs2_q <= rs2_d;
        tag_q <= tag_d;
        quo_q <= quo_d;
        rem_q <= rem_d;
        dvs_q <= dvs_d;
    end

    // Outputs: during DONE show the fresh result, otherwise the last one.
    always_comb begin
        busy_o   = (state_q != ST_IDLE);
        done_o   = (state_q == ST_DONE);
        result_o = done_o ? fix_result : res_hold_q;
        rd_tag_o = done_o ? tag_q : tag_hold_q;
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized
// requests compared against an arithmetic reference model.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic [4:0]  rd_tag_i;
    logic        flush_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_tag_o;

    int checks = 0;
    int errors = 0;

    div_unit #(.XLEN(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .op_i     (op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .rd_tag_i (rd_tag_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o),
        .rd_tag_o (rd_tag_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic (truncating division, remainder
    // sign follows dividend), with the divisor-zero rule applied.
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        if (op == 2'b00 || op == 2'b10) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end
        if (b == 32'h0) begin
            q = -1;
            r = sa;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        return (op == 2'b10 || op == 2'b11) ? r[31:0] : q[31:0];
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
`ifdef DIV_BYPASS_EN
        if (b == 32'h0 || ((op == 2'b00 || op == 2'b10) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
            return 2;
`endif
        return 34;
    endfunction

    // Issue one request in the current (IDLE) cycle, which is cycle 1, and
    // follow it to completion; returns in the IDLE cycle after DONE.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag);
        logic [31:0] exp;
        int          cyc;
        bit          seen;
        exp      = ref_div(op, a, b);
        start_i  = 1'b1;
        op_i     = op;
        rs1_i    = a;
        rs2_i    = b;
        rd_tag_i = tag;
        next_cycle();
        start_i  = 1'b0;
        rs1_i    = $urandom;
        rs2_i    = $urandom;
        rd_tag_i = 5'($urandom);
        check({name, "_busy_c2"}, 32'(busy_o), 32'd1);
        cyc  = 2;
        seen = 0;
        while (!seen && cyc <= 40) begin
            if (done_o === 1'b1) seen = 1;
            else begin
                next_cycle();
                cyc++;
            end
        end
        check({name, "_latency"}, seen ? 32'(cyc) : 32'd0, 32'(ref_lat(op, a, b)));
        check({name, "_result"}, result_o, exp);
        check({name, "_tag"}, 32'(rd_tag_o), 32'(tag));
        check({name, "_busy_done"}, 32'(busy_o), 32'd1);
        next_cycle();
        check({name, "_done_pulse"}, 32'(done_o), 32'd0);
        check({name, "_hold"}, result_o, exp);
        check({name, "_idle"}, 32'(busy_o), 32'd0);
    endtask

    // Watch for a stray completion over a fixed window.
    task automatic expect_no_done(input string name, input int ncyc);
        int hits;
        hits = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (done_o === 1'b1) hits++;
            next_cycle();
        end
        check(name, 32'(hits), 32'd0);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        bit          seen;
        int          cyc;

        rst      = 1'b1;
        start_i  = 1'b0;
        op_i     = 2'b00;
        rs1_i    = '0;
        rs2_i    = '0;
        rd_tag_i = '0;
        flush_i  = 1'b0;
        repeat (3) next_cycle();
        check("rst_busy",   32'(busy_o), 32'd0);
        check("rst_done",   32'(done_o), 32'd0);
        check("rst_result", result_o, 32'd0);
        check("rst_tag",    32'(rd_tag_o), 32'd0);
        rst = 1'b0;
        next_cycle();

        // Directed values, run back to back so each accept lands in the IDLE
        // cycle directly after the previous DONE.
        run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd5);
        run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd5);
        run_op("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2, 5'd9);
        run_op("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 5'd10);
        run_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
        run_op("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
        run_op("div_zero",   2'b00, 32'hFFFF_FFF9, 32'd0, 5'd13);
        run_op("rem_zero",   2'b10, 32'hFFFF_FFF9, 32'd0, 5'd14);
        run_op("divu_zero",  2'b01, 32'h1234_5678, 32'd0, 5'd15);
        run_op("remu_zero",  2'b11, 32'h1234_5678, 32'd0, 5'd16);
        run_op("divu_big",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31);
        run_op("div_m_m",    2'b00, 32'h8000_0000, 32'h8000_0000, 5'd1);

        // Randomized requests with a bias toward small, zero and extreme divisors.
        for (int n = 0; n < 40; n++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 15));
                3: begin rb = 32'hFFFF_FFFF; ra = 32'h8000_0000; end
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            run_op("rand", rop, ra, rb, 5'($urandom));
        end

        // Second start mid-operation is ignored; the first request completes.
        start_i = 1'b1; op_i = 2'b01; rs1_i = 32'd100; rs2_i = 32'd7; rd_tag_i = 5'd3;
        next_cycle();                                   // cycle 2
        start_i = 1'b0;
        repeat (3) next_cycle();                        // cycle 5
        start_i = 1'b1; op_i = 2'b00; rs1_i = 32'd1000; rs2_i = 32'd3; rd_tag_i = 5'd9;
        next_cycle();
        start_i = 1'b0;
        cyc = 6;
        seen = 0;
        while (!seen && cyc <= 40) begin
            if (done_o === 1'b1) seen = 1;
            else begin
                next_cycle();
                cyc++;
            end
        end
        check("ign_latency", seen ? 32'(cyc) : 32'd0, 32'd34);
        check("ign_result", result_o, 32'd14);
        check("ign_tag", 32'(rd_tag_o), 32'd3);
        next_cycle();
        expect_no_done("ign_no_second", 40);

        // Flush in cycle 10 aborts: idle in cycle 11, no completion afterwards.
        start_i = 1'b1; op_i = 2'b01; rs1_i = 32'd500; rs2_i = 32'd9; rd_tag_i = 5'd7;
        next_cycle();                                   // cycle 2
        start_i = 1'b0;
        repeat (3) next_cycle();                        // cycle 5
        start_i = 1'b1;
        next_cycle();
        start_i = 1'b0;
        repeat (4) next_cycle();                        // cycle 10
        flush_i = 1'b1;
        next_cycle();                                   // cycle 11
        flush_i = 1'b0;
        check("flush_busy", 32'(busy_o), 32'd0);
        check("flush_hold", result_o, 32'd14);
        expect_no_done("flush_no_done", 40);

        // Flush wins over a simultaneous start in IDLE.
        start_i = 1'b1; flush_i = 1'b1;
        next_cycle();
        start_i = 1'b0; flush_i = 1'b0;
        check("flush_prio_busy", 32'(busy_o), 32'd0);
        expect_no_done("flush_prio_no_done", 40);

        // Reset in cycle 20 of an operation.
        start_i = 1'b1; op_i = 2'b00; rs1_i = 32'd12345; rs2_i = 32'd17; rd_tag_i = 5'd21;
        next_cycle();                                   // cycle 2
        start_i = 1'b0;
        repeat (18) next_cycle();                       // cycle 20
        rst = 1'b1;
        next_cycle();                                   // cycle 21
        rst = 1'b0;
        check("mid_rst_busy",   32'(busy_o), 32'd0);
        check("mid_rst_done",   32'(done_o), 32'd0);
        check("mid_rst_result", result_o, 32'd0);
        check("mid_rst_tag",    32'(rd_tag_o), 32'd0);
        expect_no_done("mid_rst_no_done", 40);

        // A fresh request after reset still takes the full iteration count.
        run_op("post_rst", 2'b00, 32'd12345, 32'd17, 5'd21);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
